// File: rtl/sign_mag_subtractor.sv
// Bit-serial sign-magnitude subtractor: Out = A - B, one magnitude bit per clock.
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (A, B latched when both high)
//   A, B                 N-bit sign-magnitude minuend / subtrahend (MSB = sign)
//   out_valid/out_ready  result handshake
//   Out, ovf             sign-magnitude result, magnitude overflow flag
module sign_mag_subtractor #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Out,
   output logic         ovf
);

   localparam int unsigned M  = N - 1;                     // magnitude width
   localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;   // bit counter width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      SER  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [M-1:0]    mx_q, mx_d;
   logic [M-1:0]    mn_q, mn_d;
   logic [M-1:0]    res_q, res_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cb_q, cb_d;
   logic            rsign_q, rsign_d;
   logic            sub_q, sub_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [N-1:0]    out_q, out_d;
   logic            ovf_q, ovf_d;

   // Serial bit slice and compare helpers
   logic            bit_a, bit_b, bit_s, bit_c;
   logic            s_a, s_b_eff;
   logic [M-1:0]    m_a, m_b;
   logic [M-1:0]    res_nx;
   logic            fin_ovf;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Out       = out_q;
   assign ovf       = ovf_q;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         mx_q        <= '0;
         mn_q        <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         cb_q        <= 1'b0;
         rsign_q     <= 1'b0;
         sub_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         mx_q        <= mx_d;
         mn_q        <= mn_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         cb_q        <= cb_d;
         rsign_q     <= rsign_d;
         sub_q       <= sub_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         ovf_q       <= ovf_d;
      end
   end

   // Next-state, serial arithmetic and registered-output next values
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      mx_d        = mx_q;
      mn_d        = mn_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      cb_d        = cb_q;
      rsign_d     = rsign_q;
      sub_d       = sub_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      ovf_d       = ovf_q;

      s_a     = a_q[N-1];
      s_b_eff = ~b_q[N-1];
      m_a     = a_q[M-1:0];
      m_b     = b_q[M-1:0];

      // One-bit full adder / full subtractor on max[i], min[i], carry/borrow
      bit_a = mx_q[cnt_q];
      bit_b = mn_q[cnt_q];
      bit_s = bit_a ^ bit_b ^ cb_q;
      if (sub_q) begin
         bit_c = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & cb_q);
      end else begin
         bit_c = (bit_a & bit_b) | (cb_q & (bit_a ^ bit_b));
      end
      res_nx         = res_q;
      res_nx[cnt_q]  = bit_s;
      fin_ovf        = ~sub_q & bit_c;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = A;
               b_d        = B;
               in_ready_d = 1'b0;
               state_d    = CMP;
            end
         end
         CMP: begin
            if (m_a > m_b) begin
               mx_d    = m_a;
               mn_d    = m_b;
               rsign_d = s_a;
            end else begin
               mx_d    = m_b;
               mn_d    = m_a;
               rsign_d = s_b_eff;
            end
            sub_d   = (s_a != s_b_eff);
            cnt_d   = '0;
            cb_d    = 1'b0;
            res_d   = '0;
            state_d = SER;
         end
         SER: begin
            res_d = res_nx;
            cb_d  = bit_c;
            if (cnt_q == CW'(M - 1)) begin
               // Zero without overflow is always reported as +0
               out_d       = {rsign_q & ((res_nx != '0) | fin_ovf), res_nx};
               ovf_d       = fin_ovf;
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sign_mag_subtractor.sv
// Directed and randomised checks for sign_mag_subtractor at N=4 and N=8.
module tb_sign_mag_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       in_valid4, in_ready4, out_valid4, out_ready4, ovf4;
   logic [3:0] a4, b4, out4;

   logic       in_valid8, in_ready8, out_valid8, out_ready8, ovf8;
   logic [7:0] a8, b8, out8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sign_mag_subtractor #(.N(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4), .A(a4), .B(b4),
      .out_valid(out_valid4), .out_ready(out_ready4), .Out(out4), .ovf(ovf4)
   );

   sign_mag_subtractor #(.N(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8),
      .out_valid(out_valid8), .out_ready(out_ready8), .Out(out8), .ovf(ovf8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Independent integer model of sign-magnitude A - B for N=8
   task automatic model8(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] o, output logic v);
      int va, vb, d, mag;
      va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
      vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
      d   = va - vb;
      mag = (d < 0) ? -d : d;
      v   = (mag > 127);
      o[6:0] = 7'(mag);
      o[7]   = (d < 0) && ((o[6:0] != 7'd0) || v);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One N=4 operation; completes the output handshake when out_ready4 is high
   task automatic run4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eo, input logic eovf, input string tag);
      int w, lat;
      w = 0;
      while (!in_ready4 && w < 20) begin step(); w++; end
      check({tag, "_rdy"}, 32'(in_ready4), 32'd1);
      a4 = a; b4 = b; in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      lat = 0;
      while (!out_valid4 && lat < 20) begin step(); lat++; end
      check({tag, "_lat"}, 32'(lat), 32'd4);
      check({tag, "_out"}, 32'(out4), 32'(eo));
      check({tag, "_ovf"}, 32'(ovf4), 32'(eovf));
      if (out_ready4) begin
         step();
         check({tag, "_ovld0"}, 32'(out_valid4), 32'd0);
         check({tag, "_irdy1"}, 32'(in_ready4), 32'd1);
      end
   endtask

   initial begin
      logic [7:0] ea, eb, eo;
      logic       ev;
      int         lat, w, stall;

      rst_n = 1'b0;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_irdy", 32'(in_ready4), 32'd1);
      check("rst_ovld", 32'(out_valid4), 32'd0);
      check("rst_out",  32'(out4), 32'd0);
      check("rst_ovf",  32'(ovf4), 32'd0);
      rst_n = 1'b1;
      step();

      // Directed N=4 vectors
      run4(4'b0101, 4'b0011, 4'b0010, 1'b0, "p5_m_p3");
      run4(4'b0011, 4'b0101, 4'b1010, 1'b0, "p3_m_p5");
      run4(4'b0110, 4'b1011, 4'b0001, 1'b1, "p6_m_n3");
      run4(4'b1101, 4'b0101, 4'b1010, 1'b1, "n5_m_p5");
      run4(4'b0100, 4'b0100, 4'b0000, 1'b0, "z_eq");
      run4(4'b1000, 4'b0000, 4'b0000, 1'b0, "z_negzero");
      run4(4'b1011, 4'b1011, 4'b0000, 1'b0, "z_neg_eq");
      run4(4'b0100, 4'b1100, 4'b0000, 1'b1, "ovf_zero_mag");

      // Backpressure with an ignored in_valid pulse while busy
      out_ready4 = 1'b0;
      run4(4'b0101, 4'b0011, 4'b0010, 1'b0, "bp");
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 1) begin
            in_valid4 = 1'b1; a4 = 4'b0111; b4 = 4'b0000;
         end else begin
            in_valid4 = 1'b0;
         end
         check("bp_ovld", 32'(out_valid4), 32'd1);
         check("bp_out",  32'(out4), 32'b0010);
         check("bp_ovf",  32'(ovf4), 32'd0);
         check("bp_irdy", 32'(in_ready4), 32'd0);
      end
      in_valid4 = 1'b0;
      out_ready4 = 1'b1;
      step();
      check("bp_rel_ovld", 32'(out_valid4), 32'd0);
      check("bp_rel_irdy", 32'(in_ready4), 32'd1);
      step();
      check("bp_ign_ovld", 32'(out_valid4), 32'd0);
      check("bp_ign_irdy", 32'(in_ready4), 32'd1);

      // Reset during the second serial cycle
      a4 = 4'b0101; b4 = 4'b0011; in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      check("rmid_ovld", 32'(out_valid4), 32'd0);
      check("rmid_out",  32'(out4), 32'd0);
      check("rmid_ovf",  32'(ovf4), 32'd0);
      check("rmid_irdy", 32'(in_ready4), 32'd1);
      rst_n = 1'b1;
      step();
      run4(4'b0010, 4'b0001, 4'b0001, 1'b0, "rmid_new");

      // N=8 random regression with output stalls
      for (int k = 0; k < 1000; k++) begin
         ea = 8'($urandom);
         eb = 8'($urandom);
         if (k == 0) begin ea = 8'h7F; eb = 8'hFF; end
         if (k == 1) begin ea = 8'h80; eb = 8'h00; end
         model8(ea, eb, eo, ev);
         w = 0;
         while (!in_ready8 && w < 30) begin step(); w++; end
         check("r8_rdy", 32'(in_ready8), 32'd1);
         a8 = ea; b8 = eb; in_valid8 = 1'b1;
         step();
         in_valid8 = 1'b0;
         lat = 0;
         while (!out_valid8 && lat < 30) begin step(); lat++; end
         check("r8_lat", 32'(lat), 32'd8);
         check("r8_out", 32'(out8), 32'(eo));
         check("r8_ovf", 32'(ovf8), 32'(ev));
         stall = int'($urandom_range(0, 3));
         repeat (stall) step();
         check("r8_hold", 32'({out_valid8, ovf8, out8}), 32'({1'b1, ev, eo}));
         out_ready8 = 1'b1;
         step();
         out_ready8 = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
